// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - parametrised 2R/1W register file with bypass, pending scoreboard and clear sweep
module regfile_param #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 3,
   parameter bit ZERO_R0 = 1'b0,
   parameter bit BYPASS  = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              write,
   input  logic [ADDR_W-1:0] wr_Addr,
   input  logic [DATA_W-1:0] wr_Data,
   input  logic [ADDR_W-1:0] rd_AddrA,
   input  logic [ADDR_W-1:0] rd_AddrB,
   output logic [DATA_W-1:0] rd_DataA,
   output logic [DATA_W-1:0] rd_DataB,
   output logic              busyA,
   output logic              busyB,
   input  logic              rsv,
   input  logic [ADDR_W-1:0] rsv_Addr,
   input  logic              clr_req,
   output logic              clr_busy,
   output logic              clr_done
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] regs [DEPTH];
   logic [DEPTH-1:0]  pending;
   logic [ADDR_W-1:0] cnt;
   logic              idle, wr_en, rsv_en;
   logic              byp_a, byp_b, zero_a, zero_b;

   assign idle   = (state == IDLE);
   assign wr_en  = idle && write && !(ZERO_R0 && (wr_Addr == '0));
   assign rsv_en = idle && rsv && !(ZERO_R0 && (rsv_Addr == '0));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (clr_req) state_nxt = SWEEP;
         SWEEP:   if (&cnt) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         clr_busy <= 1'b0;
         clr_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= (state == SWEEP) ? cnt + ADDR_W'(1) : '0;
         clr_busy <= (state_nxt == SWEEP);
         clr_done <= (state_nxt == DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else if (state == SWEEP) begin
         regs[cnt] <= '0;
      end else if (wr_en) begin
         regs[wr_Addr] <= wr_Data;
      end
   end

   // The reservation is applied after the write so a same-address pair leaves the entry pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (state == SWEEP) begin
         pending[cnt] <= 1'b0;
      end else begin
         if (wr_en)  pending[wr_Addr]  <= 1'b0;
         if (rsv_en) pending[rsv_Addr] <= 1'b1;
      end
   end

   assign byp_a  = BYPASS && idle && write && (wr_Addr == rd_AddrA);
   assign byp_b  = BYPASS && idle && write && (wr_Addr == rd_AddrB);
   assign zero_a = ZERO_R0 && (rd_AddrA == '0);
   assign zero_b = ZERO_R0 && (rd_AddrB == '0);

   always_comb begin
      rd_DataA = regs[rd_AddrA];
      busyA    = pending[rd_AddrA];
      if (byp_a) begin
         rd_DataA = wr_Data;
         busyA    = 1'b0;
      end
      if (zero_a) begin
         rd_DataA = '0;
         busyA    = 1'b0;
      end
   end

   always_comb begin
      rd_DataB = regs[rd_AddrB];
      busyB    = pending[rd_AddrB];
      if (byp_b) begin
         rd_DataB = wr_Data;
         busyB    = 1'b0;
      end
      if (zero_b) begin
         rd_DataB = '0;
         busyB    = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// tb/tb_regfile_param.sv - self-checking bench for regfile_param (default, no-bypass and zero-r0 variants)
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        write, rsv, clr_req;
   logic [2:0]  wr_Addr, rd_AddrA, rd_AddrB, rsv_Addr;
   logic [15:0] wr_Data;

   logic [15:0] b_rdA, b_rdB, n_rdA, n_rdB, z_rdA, z_rdB;
   logic        b_bA, b_bB, n_bA, n_bB, z_bA, z_bB;
   logic        b_cb, b_cd, n_cb, n_cd, z_cb, z_cd;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .write(write), .wr_Addr(wr_Addr), .wr_Data(wr_Data),
      .rd_AddrA(rd_AddrA), .rd_AddrB(rd_AddrB), .rd_DataA(b_rdA), .rd_DataB(b_rdB),
      .busyA(b_bA), .busyB(b_bB), .rsv(rsv), .rsv_Addr(rsv_Addr),
      .clr_req(clr_req), .clr_busy(b_cb), .clr_done(b_cd));

   regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .write(write), .wr_Addr(wr_Addr), .wr_Data(wr_Data),
      .rd_AddrA(rd_AddrA), .rd_AddrB(rd_AddrB), .rd_DataA(n_rdA), .rd_DataB(n_rdB),
      .busyA(n_bA), .busyB(n_bB), .rsv(rsv), .rsv_Addr(rsv_Addr),
      .clr_req(clr_req), .clr_busy(n_cb), .clr_done(n_cd));

   regfile_param #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_z (
      .clk(clk), .rst_n(rst_n), .write(write), .wr_Addr(wr_Addr), .wr_Data(wr_Data),
      .rd_AddrA(rd_AddrA), .rd_AddrB(rd_AddrB), .rd_DataA(z_rdA), .rd_DataB(z_rdB),
      .busyA(z_bA), .busyB(z_bB), .rsv(rsv), .rsv_Addr(rsv_Addr),
      .clr_req(clr_req), .clr_busy(z_cb), .clr_done(z_cd));

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic pop_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed=%h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                        input logic [2:0] ra, input logic [2:0] rb,
                        input logic r, input logic [2:0] radr, input logic c);
      write = w; wr_Addr = wa; wr_Data = wd;
      rd_AddrA = ra; rd_AddrB = rb;
      rsv = r; rsv_Addr = radr; clr_req = c;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #12;
      // reset state on every address
      for (int i = 0; i < 8; i++) begin
         rd_AddrA = 3'(i); rd_AddrB = 3'(i);
         push($sformatf("rst_rdA_%0d", i), 0);
         push($sformatf("rst_rdB_%0d", i), 0);
         push($sformatf("rst_busyA_%0d", i), 0);
         push($sformatf("rst_busyB_%0d", i), 0);
         #1;
         pop_check(b_rdA); pop_check(b_rdB); pop_check(b_bA); pop_check(b_bB);
      end
      push("rst_clr_busy", 0); push("rst_clr_done", 0);
      pop_check(b_cb); pop_check(b_cd);

      @(negedge clk); rst_n = 1'b1;

      // write r5 with bypass / without bypass
      @(negedge clk); drive(1, 5, 16'hBEEF, 5, 5, 0, 0, 0);
      push("byp_rdA", 16'hBEEF); push("nobyp_rdA_old", 0); push("zr0_byp_rdA", 16'hBEEF);
      #1; pop_check(b_rdA); pop_check(n_rdA); pop_check(z_rdA);
      @(negedge clk); drive(0, 0, 0, 5, 5, 0, 0, 0);
      push("nobyp_rdA_new", 16'hBEEF); push("byp_rdA_reg", 16'hBEEF);
      #1; pop_check(n_rdA); pop_check(b_rdA);

      // reservation, write clears it with bypass, write+rsv keeps it
      @(negedge clk); drive(0, 0, 0, 3, 3, 1, 3, 0);
      push("rsv_busy_before", 0);
      #1; pop_check(b_bA);
      @(negedge clk); drive(0, 0, 0, 3, 3, 0, 0, 0);
      push("rsv_busy_after", 1); push("rsv_busyB_after", 1);
      #1; pop_check(b_bA); pop_check(b_bB);
      @(negedge clk); drive(1, 3, 16'h1234, 3, 3, 0, 0, 0);
      push("wr_busy_bypass", 0); push("wr_busy_nobyp", 1);
      #1; pop_check(b_bA); pop_check(n_bA);
      @(negedge clk); drive(0, 0, 0, 3, 3, 0, 0, 0);
      push("wr_pending_cleared", 0); push("wr_r3_data", 16'h1234);
      #1; pop_check(b_bA); pop_check(b_rdA);
      @(negedge clk); drive(1, 3, 16'h4321, 3, 3, 1, 3, 0);
      @(negedge clk); drive(0, 0, 0, 3, 3, 0, 0, 0);
      push("wr_rsv_same_busy", 1); push("wr_rsv_same_data", 16'h4321);
      #1; pop_check(b_bA); pop_check(b_rdA);

      // hard-wired zero register
      @(negedge clk); drive(1, 0, 16'hFFFF, 0, 0, 1, 0, 0);
      push("zr0_rdA_same", 0); push("nozr_rdA_byp", 16'hFFFF);
      #1; pop_check(z_rdA); pop_check(b_rdA);
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
      push("zr0_rdA", 0); push("zr0_busyA", 0); push("nozr_rdA", 16'hFFFF); push("nozr_busyA", 1);
      #1; pop_check(z_rdA); pop_check(z_bA); pop_check(b_rdA); pop_check(b_bA);

      // fill r0..r7, reserve r2 and r6
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(1, 3'(i), 16'(16'h1111 * i), 0, 0, (i == 5 || i == 7), (i == 5) ? 3'd2 : 3'd6, 0);
      end
      @(negedge clk); drive(0, 0, 0, 2, 6, 0, 0, 0);
      push("fill_busy_r2", 1); push("fill_busy_r6", 1);
      #1; pop_check(b_bA); pop_check(b_bB);
      rd_AddrA = 6; rd_AddrB = 7;
      push("fill_r6", 16'h6666); push("fill_r7", 16'h7777);
      #1; pop_check(b_rdA); pop_check(b_rdB);

      // clear sweep with simultaneous write r1
      @(negedge clk); drive(1, 1, 16'hAAAA, 4, 1, 0, 0, 1);
      for (int j = 0; j < 9; j++) begin
         @(negedge clk);
         drive(j < 8, 4, 16'h5555, 4, 1, j < 8, 4, 1);
         push($sformatf("sweep_busy_%0d", j), j < 8);
         push($sformatf("sweep_done_%0d", j), j == 8);
         push($sformatf("sweep_r4_%0d", j), (j >= 5) ? 0 : 16'h4444);
         push($sformatf("sweep_r1_%0d", j), (j >= 2) ? 0 : 16'hAAAA);
         #1; pop_check(b_cb); pop_check(b_cd); pop_check(b_rdA); pop_check(b_rdB);
      end
      @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0, 0);
      push("post_clr_done", 0);
      #1; pop_check(b_cd);
      for (int i = 0; i < 8; i++) begin
         rd_AddrA = 3'(i); rd_AddrB = 3'(i);
         push($sformatf("post_rd_%0d", i), 0);
         push($sformatf("post_busy_%0d", i), 0);
         #1; pop_check(b_rdA); pop_check(b_bB);
      end

      // reset mid-sweep
      @(negedge clk); drive(1, 7, 16'h7777, 7, 7, 0, 0, 0);
      @(negedge clk); drive(0, 0, 0, 7, 7, 0, 0, 1);
      for (int j = 0; j < 3; j++) begin
         @(negedge clk); drive(0, 0, 0, 7, 7, 0, 0, 0);
      end
      push("mid_busy_pre", 1); push("mid_r7_pre", 16'h7777);
      #1; pop_check(b_cb); pop_check(b_rdA);
      rst_n = 1'b0;
      push("mid_rst_busy", 0); push("mid_rst_done", 0); push("mid_rst_r7", 0);
      #1; pop_check(b_cb); pop_check(b_cd); pop_check(b_rdA);
      @(negedge clk); rst_n = 1'b1; drive(1, 2, 16'h2222, 2, 2, 0, 0, 0);
      @(negedge clk); drive(0, 0, 0, 2, 2, 0, 0, 0);
      push("after_rst_wr_nb", 16'h2222); push("after_rst_wr_b", 16'h2222); push("after_rst_clr_busy", 0);
      #1; pop_check(n_rdA); pop_check(b_rdA); pop_check(b_cb);

      if (sb.size() != 0) begin
         errors++;
         checks++;
         $display("FAIL sb_leftover observed=%0d expected=0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
